flash_arb: RTL

//  Round-robin arbiter/sequencer sharing one flash_ctl between NREQ requesters (CPU, loader, logger).
//  - Grants one requester at a time and latches its request fields.
//  - Issues a one-cycle read/write strobe to flash_ctl and tracks its busy handshake to completion.
//  - Returns read data and a one-cycle ack to the owning requester.

---
 rtl/flash_pkg.sv | 20 ++
 rtl/flash_arb_rr_arbiter.sv | 31 +++
 rtl/flash_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared widths, FSM state encoding and pointer helper for flash_arb
package flash_pkg;

  localparam int FLASH_ADDR_W = 16;
  localparam int FLASH_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    if (int'(idx) + 1 >= n) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/flash_arb_rr_arbiter.sv
// rtl/flash_arb_rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [2:0]      o_grant,
  output logic            o_valid
);

  logic [NREQ-1:0] w_rot;
  logic [3:0]      w_sum;

  // Rotating a doubled copy puts the ptr position at bit 0.
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_grant = 3'd0;
    o_valid = 1'b0;
    w_sum   = 4'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_sum = {1'b0, i_ptr} + 4'(i);
        if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
        o_grant = w_sum[2:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_arb.sv
// rtl/flash_arb.sv - round-robin sequencer sharing one flash_ctl between NREQ requesters
// Optional watchdog: define FLASH_ARB_TMO_EN.
module flash_arb
  import flash_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TMO_CYC = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ*FLASH_ADDR_W-1:0]   req_addr,
  input  logic [NREQ*FLASH_DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]                ack,
  output logic [FLASH_DATA_W-1:0]        rdata,
  output logic [2:0]                     owner,
  output logic                           err,
  output logic                           fc_read,
  output logic                           fc_write,
  output logic [FLASH_ADDR_W-1:0]        fc_addr,
  output logic [FLASH_DATA_W-1:0]        fc_din,
  input  logic                           fc_busy,
  input  logic [FLASH_DATA_W-1:0]        fc_dout
);

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic            r_we;
  logic            r_err;
  logic            w_tmo_hit;
  logic [2:0]      w_grant;
  logic            w_valid;
  logic [NREQ-1:0] w_ack_vec;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_valid(w_valid)
  );

  assign w_ack_vec = NREQ'(1) << owner;
  assign err       = r_err;

`ifdef FLASH_ARB_TMO_EN
  logic [15:0] r_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_tmo <= '0;
    end else if (r_state == ST_START || r_state == ST_WAIT) begin
      r_tmo <= r_tmo + 16'd1;
    end
  end

  assign w_tmo_hit = (r_state == ST_START || r_state == ST_WAIT) && (r_tmo == 16'(TMO_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 3'd0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      ack      <= '0;
      rdata    <= '0;
      owner    <= 3'd0;
      fc_read  <= 1'b0;
      fc_write <= 1'b0;
      fc_addr  <= '0;
      fc_din   <= '0;
    end else begin
      ack      <= '0;
      fc_read  <= 1'b0;
      fc_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A busy flash_ctl (including straight out of reset) blocks any new grant.
          if (w_valid && !fc_busy) begin
            owner    <= w_grant;
            r_we     <= req_we[w_grant +: 1];
            fc_write <= req_we[w_grant +: 1];
            fc_read  <= ~req_we[w_grant +: 1];
            fc_addr  <= req_addr[w_grant*FLASH_ADDR_W +: FLASH_ADDR_W];
            fc_din   <= req_wdata[w_grant*FLASH_DATA_W +: FLASH_DATA_W];
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_START;
        ST_START, ST_WAIT: begin
          if (r_state == ST_WAIT && !fc_busy) begin
            ack     <= w_ack_vec;
            if (!r_we) rdata <= fc_dout;
            r_ptr   <= wrap_inc(owner, NREQ);
            r_state <= ST_DONE;
          end else if (w_tmo_hit) begin
            ack     <= w_ack_vec;
            rdata   <= 8'hFF;
            r_err   <= 1'b1;
            r_ptr   <= wrap_inc(owner, NREQ);
            r_state <= ST_DONE;
          end else if (r_state == ST_START && fc_busy) begin
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
